// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the leading-zero counter / normaliser.
// The LZC_SIGNED_EN build option is handled in lzc_norm_pipe.sv.
package lzc_pkg;

  localparam int MAX_LZC_WIDTH = 32;
  localparam int MIN_LZC_WIDTH = 8;

  // Count width able to hold 0..width inclusive.
  function automatic int lzc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzc_norm_pipe_if.sv
// Input/result channel bundle for lzc_norm_pipe.
// Handshake: a word moves on a rising edge where valid and ready are both high;
// valid never depends on ready, and the producer holds data stable while valid && !ready.
interface lzc_norm_pipe_if #(
  parameter int WIDTH = 22
);
  import lzc_pkg::*;

  localparam int CW = lzc_cw(WIDTH);

  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             o_ready;
  logic [CW-1:0]    o_lzc;
  logic [WIDTH-1:0] o_norm;
  logic             o_zero;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_lzc, o_norm, o_zero
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_lzc, o_norm, o_zero
  );

endinterface

// File: rtl/lzc_core.sv
// Combinational width-generic leading-zero count; the highest set bit wins.
module lzc_core #(
  parameter int WIDTH = 22,
  parameter int CW    = 5
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    cnt_o,
  output logic             zero_o
);

  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
    zero_o = ~|data_i;
  end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero counter and normaliser (count in S1, shift in S2).
// Define LZC_SIGNED_EN to count redundant sign bits of a two's-complement input instead.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter int WIDTH = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  lzc_norm_pipe_if.slave     bus,
  output logic [1:0]         dbg_valid_o
);

  localparam int CW = lzc_cw(WIDTH);

  if (WIDTH < MIN_LZC_WIDTH || WIDTH > MAX_LZC_WIDTH) begin : g_bad_width
    $error("lzc_norm_pipe: WIDTH must be within 8..32");
  end

  logic             v1_q, v2_q;
  logic [WIDTH-1:0] data1_q;
  logic [CW-1:0]    cnt1_q, cnt1_d;
  logic             zero1_q, zero1_d;
  logic [CW-1:0]    lzc2_q;
  logic [WIDTH-1:0] norm2_q, norm2_d;
  logic             zero2_q;
  logic             en1, en2;

  logic [WIDTH-1:0] core_in;
  logic [CW-1:0]    core_cnt;
  logic             core_zero;

`ifdef LZC_SIGNED_EN
  // Sign-folded and shifted so the core counts only the redundant sign bits;
  // 0 and -1 both fold to zero and get the maximum count WIDTH-1.
  assign core_in = (bus.i_data ^ {WIDTH{bus.i_data[WIDTH-1]}}) << 1;
  assign cnt1_d  = core_zero ? CW'(WIDTH - 1) : core_cnt;
  assign zero1_d = ~|bus.i_data;
`else
  assign core_in = bus.i_data;
  assign cnt1_d  = core_cnt;
  assign zero1_d = core_zero;
`endif

  lzc_core #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_core (
    .data_i (core_in),
    .cnt_o  (core_cnt),
    .zero_o (core_zero)
  );

  // No skid buffer: ready ripples combinationally from o_ready through both stages.
  assign en2         = !v2_q || bus.o_ready;
  assign en1         = !v1_q || en2;
  assign bus.i_ready = en1;

  // A shift by WIDTH (all-zero input) yields 0.
  assign norm2_d = data1_q << cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      cnt1_q  <= '0;
      zero1_q <= 1'b0;
    end else if (en1) begin
      v1_q <= bus.i_valid;
      if (bus.i_valid) begin
        data1_q <= bus.i_data;
        cnt1_q  <= cnt1_d;
        zero1_q <= zero1_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      lzc2_q  <= '0;
      norm2_q <= '0;
      zero2_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        lzc2_q  <= cnt1_q;
        norm2_q <= norm2_d;
        zero2_q <= zero1_q;
      end
    end
  end

  assign bus.o_valid = v2_q;
  assign bus.o_lzc   = lzc2_q;
  assign bus.o_norm  = norm2_q;
  assign bus.o_zero  = zero2_q;
  assign dbg_valid_o = {v2_q, v1_q};

endmodule
